// File: rtl/alu_hs_top.sv
// ---------------------------------------------------------------------------
// alu_hs_top
//
// Handshaked 16-function ALU sitting between an operand issue stage and a
// result writeback stage. One operation is in flight at a time. Every
// non-divide operation completes in a single cycle. The result is held
// stable until the consumer takes it.
//
// Optional feature macro: ALU_DIV_EN
//   defined   : an iterative restoring signed divider is built. Opcode 0011
//               with B != 0 spends W cycles in the DIV state and returns a
//               quotient (truncated toward zero) and a remainder (sign of
//               the dividend).
//   undefined : no divider logic. Opcode 0011 completes in one cycle with
//               Arith_OUT=0, Rem_OUT=0, Div_Err=1.
//
// Ports (W = OP_DATA_WIDTH):
//   CLK          in   rising-edge clock
//   RST          in   synchronous, active-high reset
//   IN_VALID     in   operation offered
//   IN_READY     out  block can accept (0 while RST=1)
//   A, B         in   W-bit signed operands
//   ALU_FUN      in   4-bit opcode
//   OUT_VALID    out  result valid
//   OUT_READY    in   consumer takes the result
//   Arith_OUT    out  2W-bit signed arithmetic result
//   Rem_OUT      out  W-bit signed division remainder
//   Carry_OUT    out  unsigned carry (add) / borrow (sub)
//   Div_Err      out  divide by zero
//   Logic_OUT    out  W-bit bitwise result
//   CMP_OUT      out  2-bit compare code
//   Shift_OUT    out  W-bit shift result
//   Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag  out  result class
// ---------------------------------------------------------------------------
module alu_hs_top #(
    parameter int OP_DATA_WIDTH = 16
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic [OP_DATA_WIDTH-1:0]     A,
    input  logic [OP_DATA_WIDTH-1:0]     B,
    input  logic [3:0]                   ALU_FUN,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [2*OP_DATA_WIDTH-1:0]   Arith_OUT,
    output logic [OP_DATA_WIDTH-1:0]     Rem_OUT,
    output logic                         Carry_OUT,
    output logic                         Div_Err,
    output logic [OP_DATA_WIDTH-1:0]     Logic_OUT,
    output logic [1:0]                   CMP_OUT,
    output logic [OP_DATA_WIDTH-1:0]     Shift_OUT,
    output logic                         Arith_Flag,
    output logic                         Logic_Flag,
    output logic                         CMP_Flag,
    output logic                         Shift_Flag
);

    localparam int W = OP_DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Every registered result output lives in one word so that clearing and
    // loading are single assignments.
    typedef struct packed {
        logic [2*W-1:0] arith;
        logic [W-1:0]   rem;
        logic           carry;
        logic           err;
        logic [W-1:0]   lgc;
        logic [1:0]     cmp;
        logic [W-1:0]   shf;
        logic [3:0]     flags;   // {arith, logic, cmp, shift}
    } result_t;

    state_e         state_q;
    logic           out_valid_q;
    result_t        res_q;
    result_t        res_d;
    logic           start_div_d;
    logic           accept_s;
    logic [2*W-1:0] a_ext_s;
    logic [2*W-1:0] b_ext_s;

    // Ready depends only on state, reset and the consumer; never on IN_VALID.
    assign IN_READY = !RST && ((state_q == ST_IDLE) ||
                               ((state_q == ST_DONE) && OUT_READY));
    assign accept_s = IN_VALID && IN_READY;

    assign OUT_VALID  = out_valid_q;
    assign Arith_OUT  = res_q.arith;
    assign Rem_OUT    = res_q.rem;
    assign Carry_OUT  = res_q.carry;
    assign Div_Err    = res_q.err;
    assign Logic_OUT  = res_q.lgc;
    assign CMP_OUT    = res_q.cmp;
    assign Shift_OUT  = res_q.shf;
    assign Arith_Flag = res_q.flags[3];
    assign Logic_Flag = res_q.flags[2];
    assign CMP_Flag   = res_q.flags[1];
    assign Shift_Flag = res_q.flags[0];

    // Single-cycle result computed from the live operands; loaded on accept.
    always_comb begin
        a_ext_s     = {{W{A[W-1]}}, A};
        b_ext_s     = {{W{B[W-1]}}, B};
        res_d       = '0;
        start_div_d = 1'b0;
        case (ALU_FUN)
            4'b0000: begin
                res_d.arith = a_ext_s + b_ext_s;
                // MSB carry-out rebuilt from the MSB sum bit: cin = s ^ a ^ b.
                res_d.carry = (A[W-1] & B[W-1]) |
                              ((A[W-1] ^ B[W-1]) & ~res_d.arith[W-1]);
                res_d.flags = 4'b1000;
            end
            4'b0001: begin
                res_d.arith = a_ext_s - b_ext_s;
                res_d.carry = (A < B);
                res_d.flags = 4'b1000;
            end
            4'b0010: begin
                res_d.arith = a_ext_s * b_ext_s;
                res_d.flags = 4'b1000;
            end
            4'b0011: begin
                res_d.flags = 4'b1000;
                res_d.err   = 1'b1;
`ifdef ALU_DIV_EN
                if (B == '0) begin
                    res_d.rem = A;
                end else begin
                    res_d.err   = 1'b0;
                    start_div_d = 1'b1;
                end
`endif
            end
            4'b0100: begin res_d.lgc = A & B;    res_d.flags = 4'b0100; end
            4'b0101: begin res_d.lgc = A | B;    res_d.flags = 4'b0100; end
            4'b0110: begin res_d.lgc = ~(A & B); res_d.flags = 4'b0100; end
            4'b0111: begin res_d.lgc = ~(A | B); res_d.flags = 4'b0100; end
            4'b1000: begin res_d.cmp = 2'd0;     res_d.flags = 4'b0010; end
            4'b1001: begin
                res_d.cmp   = (A == B) ? 2'd1 : 2'd0;
                res_d.flags = 4'b0010;
            end
            4'b1010: begin
                res_d.cmp   = ($signed(A) > $signed(B)) ? 2'd2 : 2'd0;
                res_d.flags = 4'b0010;
            end
            4'b1011: begin
                res_d.cmp   = ($signed(A) < $signed(B)) ? 2'd3 : 2'd0;
                res_d.flags = 4'b0010;
            end
            4'b1100: begin res_d.shf = {1'b0, A[W-1:1]}; res_d.flags = 4'b0001; end
            4'b1101: begin res_d.shf = {A[W-2:0], 1'b0}; res_d.flags = 4'b0001; end
            4'b1110: begin res_d.shf = {1'b0, B[W-1:1]}; res_d.flags = 4'b0001; end
            4'b1111: begin res_d.shf = {B[W-2:0], 1'b0}; res_d.flags = 4'b0001; end
            default: begin
                res_d       = '0;
                start_div_d = 1'b0;
            end
        endcase
    end

`ifdef ALU_DIV_EN
    localparam int CW = $clog2(W);

    logic [W-1:0]   div_den_q;     // divisor magnitude
    logic [W-1:0]   div_quo_q;     // dividend bits shift out, quotient bits shift in
    logic [W-1:0]   div_rem_q;     // partial remainder magnitude
    logic [CW-1:0]  div_cnt_q;
    logic           div_qneg_q;
    logic           div_rneg_q;
    logic [W-1:0]   a_mag_s;
    logic [W-1:0]   b_mag_s;
    logic [W:0]     div_trial_s;
    logic [W:0]     div_diff_s;
    logic           div_ge_s;
    logic [W-1:0]   div_rem_next_s;
    logic [W-1:0]   div_quo_next_s;
    logic [2*W-1:0] div_quo_ext_s;
    result_t        div_res_s;

    // One restoring step plus sign application of the final step's values.
    always_comb begin
        a_mag_s        = A[W-1] ? (-A) : A;
        b_mag_s        = B[W-1] ? (-B) : B;
        div_trial_s    = {div_rem_q, div_quo_q[W-1]};
        div_diff_s     = div_trial_s - {1'b0, div_den_q};
        // The divisor magnitude is at most 2^(W-1), so a negative trial
        // difference always lands with bit W set.
        div_ge_s       = ~div_diff_s[W];
        div_rem_next_s = div_ge_s ? div_diff_s[W-1:0] : div_trial_s[W-1:0];
        div_quo_next_s = {div_quo_q[W-2:0], div_ge_s};
        div_quo_ext_s  = {{W{1'b0}}, div_quo_next_s};
        div_res_s       = '0;
        div_res_s.arith = div_qneg_q ? (-div_quo_ext_s) : div_quo_ext_s;
        div_res_s.rem   = div_rneg_q ? (-div_rem_next_s) : div_rem_next_s;
        div_res_s.flags = 4'b1000;
    end
`endif

    // Control FSM with registered result outputs and divider datapath.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            res_q       <= '0;
`ifdef ALU_DIV_EN
            div_den_q   <= '0;
            div_quo_q   <= '0;
            div_rem_q   <= '0;
            div_cnt_q   <= '0;
            div_qneg_q  <= 1'b0;
            div_rneg_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        if (start_div_d) begin
                            state_q     <= ST_DIV;
                            out_valid_q <= 1'b0;
                            res_q       <= '0;
`ifdef ALU_DIV_EN
                            div_den_q   <= b_mag_s;
                            div_quo_q   <= a_mag_s;
                            div_rem_q   <= '0;
                            div_cnt_q   <= '0;
                            div_qneg_q  <= A[W-1] ^ B[W-1];
                            div_rneg_q  <= A[W-1];
`endif
                        end else begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            res_q       <= res_d;
                        end
                    end else if ((state_q == ST_DONE) && OUT_READY) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        res_q       <= '0;
                    end else begin
                        state_q     <= state_q;
                    end
                end
`ifdef ALU_DIV_EN
                ST_DIV: begin
                    if (div_cnt_q == CW'(W - 1)) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        res_q       <= div_res_s;
                    end else begin
                        div_rem_q   <= div_rem_next_s;
                        div_quo_q   <= div_quo_next_s;
                        div_cnt_q   <= div_cnt_q + CW'(1);
                    end
                end
`endif
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    res_q       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_hs_top.sv
module tb_alu_hs_top;

    localparam int W = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [W-1:0]  A = 16'd0;
    logic [W-1:0]  B = 16'd0;
    logic [3:0]    ALU_FUN = 4'd0;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b0;
    logic [2*W-1:0] Arith_OUT;
    logic [W-1:0]  Rem_OUT;
    logic          Carry_OUT;
    logic          Div_Err;
    logic [W-1:0]  Logic_OUT;
    logic [1:0]    CMP_OUT;
    logic [W-1:0]  Shift_OUT;
    logic          Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;

    typedef struct {
        logic [31:0] arith;
        logic [15:0] rem;
        logic        carry;
        logic        err;
        logic [15:0] lg;
        logic [1:0]  cmp;
        logic [15:0] sh;
        logic [3:0]  fl;
        int          due;
        bit          seen;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    alu_hs_top #(.OP_DATA_WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A(A), .B(B), .ALU_FUN(ALU_FUN), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .Arith_OUT(Arith_OUT), .Rem_OUT(Rem_OUT),
        .Carry_OUT(Carry_OUT), .Div_Err(Div_Err), .Logic_OUT(Logic_OUT),
        .CMP_OUT(CMP_OUT), .Shift_OUT(Shift_OUT), .Arith_Flag(Arith_Flag),
        .Logic_Flag(Logic_Flag), .CMP_Flag(CMP_Flag), .Shift_Flag(Shift_Flag)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference behaviour; lat counts edges from accept until a consumer sees OUT_VALID.
    function automatic exp_t model(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        exp_t   e;
        int     sa, sb, q, r;
        longint p;
        sa = int'($signed(a));
        sb = int'($signed(b));
        e.arith = 32'd0; e.rem = 16'd0; e.carry = 1'b0; e.err = 1'b0;
        e.lg = 16'd0; e.cmp = 2'd0; e.sh = 16'd0; e.fl = 4'd0;
        e.due = 1; e.seen = 1'b0;
        case (f)
            4'h0: begin e.arith = 32'(sa + sb); e.carry = ((int'(a) + int'(b)) > 65535); e.fl = 4'b1000; end
            4'h1: begin e.arith = 32'(sa - sb); e.carry = (a < b); e.fl = 4'b1000; end
            4'h2: begin p = longint'(sa) * longint'(sb); e.arith = p[31:0]; e.fl = 4'b1000; end
            4'h3: begin
                e.fl  = 4'b1000;
                e.err = 1'b1;
`ifdef ALU_DIV_EN
                if (b == 16'd0) begin
                    e.rem = a;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    e.arith = 32'(q);
                    e.rem   = 16'(r);
                    e.err   = 1'b0;
                    e.due   = 17;
                end
`endif
            end
            4'h4: begin e.lg = a & b;    e.fl = 4'b0100; end
            4'h5: begin e.lg = a | b;    e.fl = 4'b0100; end
            4'h6: begin e.lg = ~(a & b); e.fl = 4'b0100; end
            4'h7: begin e.lg = ~(a | b); e.fl = 4'b0100; end
            4'h8: begin e.cmp = 2'd0; e.fl = 4'b0010; end
            4'h9: begin e.cmp = (a == b) ? 2'd1 : 2'd0; e.fl = 4'b0010; end
            4'hA: begin e.cmp = (sa > sb) ? 2'd2 : 2'd0; e.fl = 4'b0010; end
            4'hB: begin e.cmp = (sa < sb) ? 2'd3 : 2'd0; e.fl = 4'b0010; end
            4'hC: begin e.sh = a >> 1; e.fl = 4'b0001; end
            4'hD: begin e.sh = a << 1; e.fl = 4'b0001; end
            4'hE: begin e.sh = b >> 1; e.fl = 4'b0001; end
            default: begin e.sh = b << 1; e.fl = 4'b0001; end
        endcase
        return e;
    endfunction

    function automatic logic [127:0] all_outs();
        return 128'({Arith_OUT, Rem_OUT, Carry_OUT, Div_Err, Logic_OUT, CMP_OUT,
                     Shift_OUT, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag, OUT_VALID});
    endfunction

    // Offer one op; push its expectation only when the accept is certain.
    task automatic send(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b, input logic rdy);
        exp_t e;
        int   guard;
        guard = 0;
        @(negedge CLK);
        IN_VALID = 1'b1; ALU_FUN = f; A = a; B = b; OUT_READY = rdy;
        #1;
        while (!IN_READY && guard < 200) begin
            @(negedge CLK);
            OUT_READY = 1'b1;
            #1;
            guard++;
        end
        if (!IN_READY) begin
            chk("accept_timeout", 128'(IN_READY), 128'd1);
            IN_VALID = 1'b0;
        end else begin
            e = model(f, a, b);
            e.due = e.due + cyc;
            sb_q.push_back(e);
            @(posedge CLK);
            #1;
            IN_VALID = 1'b0;
            A = 16'($urandom);
            B = 16'($urandom);
            ALU_FUN = 4'($urandom);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        @(negedge CLK);
        OUT_READY = 1'b1;
        while (sb_q.size() != 0 && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        chk("drain_empty", 128'(sb_q.size()), 128'd0);
    endtask

    // Scoreboard: compare every cycle a result is presented, pop on handshake.
    always begin
        @(negedge CLK);
        #2;
        if (!RST && OUT_VALID) begin
            if (sb_q.size() == 0) begin
                chk("spurious_valid", 128'(OUT_VALID), 128'd0);
            end else begin
                if (!sb_q[0].seen) begin
                    chk("latency", 128'(cyc), 128'(sb_q[0].due));
                    sb_q[0].seen = 1'b1;
                end
                chk("arith", 128'(Arith_OUT), 128'(sb_q[0].arith));
                chk("rem",   128'(Rem_OUT),   128'(sb_q[0].rem));
                chk("carry", 128'(Carry_OUT), 128'(sb_q[0].carry));
                chk("div_err", 128'(Div_Err), 128'(sb_q[0].err));
                chk("logic", 128'(Logic_OUT), 128'(sb_q[0].lg));
                chk("cmp",   128'(CMP_OUT),   128'(sb_q[0].cmp));
                chk("shift", 128'(Shift_OUT), 128'(sb_q[0].sh));
                chk("flags", 128'({Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag}), 128'(sb_q[0].fl));
                if (OUT_READY) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] ra, rb;
        // Reset held for two cycles
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_outs", all_outs(), 128'd0);
        chk("rst_in_ready", 128'(IN_READY), 128'd0);
        RST = 1'b0;
        @(negedge CLK);
        #1;
        chk("ready_after_rst", 128'(IN_READY), 128'd1);

        // Add / sub with carry and borrow
        send(4'b0000, 16'hFFFC, 16'hFFFB, 1'b1);
        send(4'b0001, 16'h0004, 16'h0005, 1'b1);
        send(4'b0010, 16'hFFFD, 16'h0007, 1'b1);

        // Divide: quotient toward zero, remainder takes dividend sign
        send(4'b0011, 16'hFFF6, 16'h0003, 1'b1);
`ifdef ALU_DIV_EN
        repeat (16) begin
            @(negedge CLK);
            #1;
            chk("div_in_ready", 128'(IN_READY), 128'd0);
        end
`endif
        send(4'b0011, 16'h8000, 16'hFFFF, 1'b1);
        send(4'b0011, 16'h0007, 16'h0000, 1'b1);
        drain();

        // Backpressure: result held, no accept while consumer stalls
        send(4'b0100, 16'h0005, 16'h000B, 1'b0);
        repeat (3) begin
            @(negedge CLK);
            #1;
            chk("bp_in_ready", 128'(IN_READY), 128'd0);
            chk("bp_valid", 128'(OUT_VALID), 128'd1);
        end
        // Take the result and accept the next op on the same edge
        send(4'b1010, 16'h0005, 16'h0004, 1'b1);
        drain();

        // Reset in the middle of a divide aborts it
        send(4'b0011, 16'd1000, 16'd7, 1'b0);
        repeat (8) @(negedge CLK);
        RST = 1'b1;
        sb_q.delete();
        @(negedge CLK);
        #1;
        chk("abort_outs", all_outs(), 128'd0);
        chk("abort_in_ready", 128'(IN_READY), 128'd0);
        RST = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            #1;
            chk("abort_no_valid", all_outs(), 128'd0);
        end
        send(4'b1111, 16'h1234, 16'h000A, 1'b1);
        drain();

        // Random mix with boundary operands and random stalls
        repeat (60) begin
            ra = ($urandom_range(0, 4) == 0) ? 16'h8000 : 16'($urandom);
            case ($urandom_range(0, 5))
                0:       rb = 16'h0000;
                1:       rb = 16'hFFFF;
                default: rb = 16'($urandom);
            endcase
            send(4'($urandom_range(0, 15)), ra, rb, 1'($urandom_range(0, 1)));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_hs_top.md
# alu_hs_top

Parametrised, handshaked successor to the structural ALU: same 16-function opcode map, now with a valid/ready interface on both sides, output backpressure, an iterative signed divider that also returns a remainder, and a divide-by-zero error. It sits between an operand issue stage and a result writeback stage. It accepts one operation at a time, holds the result until it is taken, and runs every non-divide operation in one cycle.

## Interface
- OP_DATA_WIDTH, 16: operand width W (≥4); Arith_OUT is 2W, Rem_OUT is W.
- CLK  in  1  rising-edge clock
- RST  in  1  reset, synchronous and active-high
- IN_VALID  in  1  operation offered
- IN_READY  out  1  block can accept; forced 0 while RST=1
- A, B  in  W each  signed operands
- ALU_FUN  in  4  opcode
- OUT_VALID  out  1  result valid
- OUT_READY  in  1  consumer takes result
- Arith_OUT  out  2W  signed arithmetic result
- Rem_OUT  out  W  signed division remainder
- Carry_OUT  out  1  unsigned carry/borrow of add/sub
- Div_Err  out  1  divide by zero
- Logic_OUT  out  W
- CMP_OUT  out  2
- Shift_OUT  out  W
- Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag  out  1 each  result class

## Operation
- Opcodes:
  - 0000 add, 0001 sub, 0010 mul, 0011 div.
  - 0100 AND, 0101 OR, 0110 NAND, 0111 NOR.
  - 1000 CMP NOP→0; 1001 EQ→1 else 0; 1010 A>B (signed)→2 else 0; 1011 A<B→3 else 0.
  - 1100 A>>1, 1101 A<<1, 1110 B>>1, 1111 B<<1; all logical, truncated to W.
- Handshake:
  - Accept occurs on the edge where IN_VALID & IN_READY; A, B and ALU_FUN are captured then.
  - Later input changes are ignored until the next accept.
- FSM has three states: IDLE, DIV, DONE.
  - IDLE: IN_READY=1. Accept of a non-div op, or of div with B=0 → DONE. Accept of div with B≠0 → DIV.
  - DIV: restoring divide on magnitudes, one quotient bit per cycle, W cycles, then → DONE with signs applied. IN_READY=0.
  - DONE: OUT_VALID=1 and all result outputs held stable. IN_READY=OUT_READY.
  - From DONE, if OUT_READY with no new accept → IDLE. A simultaneous accept → DONE or DIV per the new op, so back-to-back results need no idle gap.
- Arithmetic:
  - Add/sub results are sign-extended to 2W. Carry_OUT is the carry (add) or borrow (sub, unsigned A<B) of the W-bit operation on the raw bit patterns. Carry_OUT=0 for all other ops.
  - Mul produces the full signed 2W product.
  - Div truncates toward zero. Arith_OUT is the sign-extended quotient; the remainder takes the dividend's sign. (−2^(W−1))/(−1) gives +2^(W−1) exactly in Arith_OUT.
  - B=0: Arith_OUT=0, Rem_OUT=A, Div_Err=1.
- Flags and unused outputs:
  - While OUT_VALID=1, exactly one class flag is 1 (arith for opcodes 00xx, logic 01xx, CMP 10xx, shift 11xx).
  - Outputs of the non-selected classes, Rem_OUT (non-div) and Div_Err (non-div) are 0.
- Reset:
  - Every output is 0 and state is IDLE.
  - RST during DIV or DONE aborts the operation; no OUT_VALID for it.

## Timing
- Non-div ops and div-by-zero: accept at edge k → OUT_VALID from edge k+1.
- Div with B≠0: accept at edge k → OUT_VALID from edge k+W+1 (W=16: 17 cycles).
- Results stay valid until the edge where OUT_READY=1; OUT_VALID drops after that edge unless a new non-div op was accepted on it.
- IN_READY is combinational from state and OUT_READY. There is no combinational path from IN_VALID to IN_READY.

## Configuration
- ALU_DIV_EN defined: the iterative divider and the DIV state are built, as described above.
- ALU_DIV_EN undefined: no divider logic. Opcode 0011 completes in 1 cycle with Arith_OUT=0, Rem_OUT=0, Div_Err=1, Arith_Flag=1.

## Test plan
- Reset: RST=1 for 2 cycles → all outputs 0 and IN_READY=0; IN_READY=1 the cycle after release.
- Add −4+−5 (0000) → one cycle later Arith_OUT=−9, Carry_OUT=1, flags {A,L,C,S}=1000; sub 4−5 → −1, Carry_OUT=1.
- Div −10/3 with ALU_DIV_EN → IN_READY=0 for 16 cycles; OUT_VALID at accept+17 with Arith_OUT=−3, Rem_OUT=−1, Div_Err=0. Also −32768/−1 → Arith_OUT=32768.
- Div 7/0 → OUT_VALID at accept+1 with Arith_OUT=0, Rem_OUT=7, Div_Err=1, Arith_Flag=1.
- Backpressure:
  - AND 0x0005,0x000B with OUT_READY=0 for 3 cycles → Logic_OUT=0x0001 held and IN_READY=0 throughout.
  - Then OUT_READY=1 with IN_VALID carrying CMP_GT 5,4 → next cycle CMP_OUT=2, flags 0010, no idle gap.
- RST asserted at cycle 8 of a divide → no OUT_VALID for that divide, all outputs 0; a following B<<1 with B=0x000A → Shift_OUT=0x0014, flags 0001.
